// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude converter.
package twos_to_signmag_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_negate_bit.sv
// One bit-slice of a serial negator: copy bits until the first one, invert afterwards.
module serial_negate_bit (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic neg,
    input  logic b,
    output logic r,
    output logic seen
);

    assign r = b ^ (neg & seen);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seen <= 1'b0;
        end else if (enable) begin
            seen <= seen | b;
        end
    end

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Converts a two's-complement word to sign-magnitude one bit per clock, LSB first.
module twos_to_signmag_serial
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [WIDTH-1:0]        out_mag,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   mag;
    logic               sign;
    logic               load;
    logic               shifting;
    logic               last_bit;
    logic               r;
    logic               seen;

    assign load     = (state == IDLE) && in_valid;
    assign shifting = (state == SHIFT);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    serial_negate_bit u_neg (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (shifting),
        .neg    (sign),
        .b      (sreg[0]),
        .r      (r),
        .seen   (seen)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter is control and is reset; operand/result registers are not,
    // because the outputs are gated by state and never expose stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shifting) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sreg <= in_data;
            sign <= in_data[WIDTH-1];
        end else if (shifting) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
            mag  <= {r, mag[WIDTH-1:1]};
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = shifting;
    assign out_valid = (state == DONE);
    assign out_sign  = out_valid & sign;
    assign out_mag   = out_valid ? mag : '0;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed self-checking bench for twos_to_signmag_serial at WIDTH=4.
module tb_twos_to_signmag_serial;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sign;
    logic [3:0] out_mag;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    twos_to_signmag_serial #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one word, measure latency, check result, then drain it.
    task automatic convert(input string tag, input logic [3:0] d,
                           input logic exp_sign, input logic [3:0] exp_mag);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 5);
        check({tag, "_sign"}, out_sign, exp_sign);
        check({tag, "_mag"}, out_mag, exp_mag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        logic       stable;
        logic       saw_valid;
        int         n;
        int         last_accept;
        logic [3:0] v;
        logic [3:0] exp_m;
        logic       taken;

        // Reset held two cycles
        reset = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sign", out_sign, 0);
        check("rst_out_mag", out_mag, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Directed values including extremes
        convert("neg3", 4'b1101, 1'b1, 4'b0011);
        convert("min", 4'b1000, 1'b1, 4'b1000);
        convert("max", 4'b0111, 1'b0, 4'b0111);
        convert("zero", 4'b0000, 1'b0, 4'b0000);
        convert("neg1", 4'b1111, 1'b1, 4'b0001);

        // Backpressure: hold DONE for 10 cycles with a competing in_valid
        in_data  = 4'b1010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_latency", n, 5);
        in_data  = 4'b0011;
        in_valid = 1'b1;
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(out_valid === 1'b1 && out_sign === 1'b1 && out_mag === 4'b0110
                  && in_ready === 1'b0 && busy === 1'b0))
                stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1);
        check("bp_mag", out_mag, 4'b0110);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_sign", out_sign, 0);
        check("bp_release_mag", out_mag, 0);
        tick();
        in_valid = 1'b0;
        check("bp_accept_busy", busy, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_next_latency", n, 5);
        check("bp_next_sign", out_sign, 0);
        check("bp_next_mag", out_mag, 4'b0011);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset at the second SHIFT cycle of -5
        in_data  = 4'b1011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("mid_no_valid", saw_valid, 0);
        convert("after_rst", 4'b0010, 1'b0, 4'b0010);

        // All 16 operands, back-to-back offers, random consumer stalls
        last_accept = -100;
        for (int k = 0; k < 16; k++) begin
            v        = 4'(k);
            in_data  = v;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            check("ex_ready_seen", in_ready, 1);
            if (k > 0) check("ex_interval_ge6", (cyc - last_accept) >= 6, 1);
            last_accept = cyc;
            tick();
            n = 1;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            exp_m = v[3] ? (~v + 4'd1) : v;
            check("ex_latency", n, 5);
            check("ex_sign", out_sign, v[3]);
            check("ex_mag", out_mag, exp_m);
            check("ex_no_ready_in_done", in_ready, 0);
            in_data = 4'(k + 1);
            taken = 1'b0;
            n = 0;
            while (!taken && n < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                taken = out_ready;
                tick();
                n++;
            end
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
